// File: rtl/key_sequencer.sv
// rtl/key_sequencer.sv - queued key-injection controller driving the CoCo key matrix
// FIFO of key codes feeding a timed LEAD/PRESS/GAP sequencer on a registered key_code.
module key_sequencer #(
  parameter int DEPTH       = 16,
  parameter int HOLD_CYCLES = 1000000,
  parameter int GAP_CYCLES  = 1000000,
  parameter int SHIFT_LEAD  = 250000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic [6:0]               in_code,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [6:0]               key_code,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int MAX_A = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int MAXP  = (MAX_A > SHIFT_LEAD) ? MAX_A : SHIFT_LEAD;
  localparam int CW    = (MAXP > 1) ? $clog2(MAXP + 1) : 1;

  localparam logic [6:0] IDLE_CODE  = 7'h7F;
  localparam logic [6:0] SHIFT_CODE = 7'h3F;

  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);
  localparam logic [CW-1:0] LEAD_LOAD = CW'((SHIFT_LEAD > 0) ? SHIFT_LEAD - 1 : 0);

  typedef enum logic [1:0] {IDLE, LEAD, PRESS, GAP} state_t;

  logic [6:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          avail_q, avail_d;
  logic [6:0]    cur_q, cur_d;
  logic [6:0]    key_q, key_d;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q, state_d;

  logic full, push, pop;
  logic [6:0] head;

  always_comb begin
    full     = (count_q == (AW + 1)'(DEPTH));
    in_ready = !reset && !full && !flush;
    push     = in_valid && in_ready;
    // avail_q is a registered not-empty view, so a freshly written entry is
    // seen by the sequencer one cycle after it lands.
    pop      = (state_q == IDLE) && avail_q && (count_q != '0) && !flush;
    head     = mem_q[rd_ptr_q];

    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
    avail_d  = (count_q != '0) && !flush;
    cur_d    = pop ? head : cur_q;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        key_d = IDLE_CODE;
        if (pop) begin
          if (!head[6] && SHIFT_LEAD > 0) begin
            state_d = LEAD;
            key_d   = SHIFT_CODE;
            cnt_d   = LEAD_LOAD;
          end else begin
            state_d = PRESS;
            key_d   = head;
            cnt_d   = HOLD_LOAD;
          end
        end
      end
      LEAD: begin
        if (cnt_q == '0) begin
          state_d = PRESS;
          key_d   = cur_q;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PRESS: begin
        if (cnt_q == '0) begin
          state_d = GAP;
          key_d   = IDLE_CODE;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      key_d   = IDLE_CODE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      avail_q  <= 1'b0;
      cur_q    <= IDLE_CODE;
      key_q    <= IDLE_CODE;
      cnt_q    <= '0;
      state_q  <= IDLE;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      avail_q  <= avail_d;
      cur_q    <= cur_d;
      key_q    <= key_d;
      cnt_q    <= cnt_d;
      state_q  <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_code;
  end

  assign key_code   = key_q;
  assign fifo_count = count_q;
  assign busy       = (count_q != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_key_sequencer.sv
// tb/tb_key_sequencer.sv - directed scoreboard bench for key_sequencer
// Two instances: shift lead of 2 cycles and shift lead disabled.
module tb_key_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, in_valid, flush, in_ready, busy;
  logic [6:0] in_code, key_code;
  logic [2:0] fifo_count;
  logic       in_valid0, flush0, in_ready0, busy0;
  logic [6:0] in_code0, key_code0;
  logic [2:0] fifo_count0;

  int checks = 0;
  int errors = 0;
  logic [6:0] exp_q[$];
  logic [6:0] exp0_q[$];

  key_sequencer #(.DEPTH(4), .HOLD_CYCLES(4), .GAP_CYCLES(3), .SHIFT_LEAD(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_code(in_code),
    .in_ready(in_ready), .flush(flush), .key_code(key_code), .busy(busy),
    .fifo_count(fifo_count)
  );

  key_sequencer #(.DEPTH(4), .HOLD_CYCLES(4), .GAP_CYCLES(3), .SHIFT_LEAD(0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_code(in_code0),
    .in_ready(in_ready0), .flush(flush0), .key_code(key_code0), .busy(busy0),
    .fifo_count(fifo_count0)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    logic [6:0] e;
    @(posedge clk);
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("key_code", {1'b0, key_code}, {1'b0, e});
    end
    if (exp0_q.size() > 0) begin
      e = exp0_q.pop_front();
      chk("key_code_nolead", {1'b0, key_code0}, {1'b0, e});
    end
  endtask

  // Per-key expectation: [shift lead] hold, gap, then the one IDLE slot.
  task automatic sb_key(input bit sel, input logic [6:0] c, input int lead);
    logic [6:0] s[$];
    if (!c[6]) for (int i = 0; i < lead; i++) s.push_back(7'h3F);
    for (int i = 0; i < 4; i++) s.push_back(c);
    for (int i = 0; i < 4; i++) s.push_back(7'h7F);
    foreach (s[i]) begin
      if (sel) exp0_q.push_back(s[i]);
      else     exp_q.push_back(s[i]);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() > 0 || exp0_q.size() > 0) && n < 500) begin
      step();
      n++;
    end
    chk("drain_bound", {7'd0, (n < 500)}, 8'd1);
  endtask

  task automatic push_one(input logic [6:0] c);
    in_valid = 1'b1;
    in_code  = c;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    logic [6:0] bp [6];
    int idx, guard;
    logic acc;

    bp[0] = 7'h4A; bp[1] = 7'h0A; bp[2] = 7'h7F;
    bp[3] = 7'h3F; bp[4] = 7'h15; bp[5] = 7'h6C;

    reset = 1'b1; in_valid = 1'b0; in_code = 7'h00; flush = 1'b0;
    in_valid0 = 1'b0; in_code0 = 7'h00; flush0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key", {1'b0, key_code}, 8'h7F);
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_count", {5'd0, fifo_count}, 8'd0);
    chk("rst_ready", {7'd0, in_ready}, 8'd0);
    chk("rst_key_nolead", {1'b0, key_code0}, 8'h7F);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {7'd0, in_ready}, 8'd1);

    // plain key
    push_one(7'h4A);
    exp_q.push_back(7'h7F);
    sb_key(1'b0, 7'h4A, 2);
    drain();
    chk("plain_busy_end", {7'd0, busy}, 8'd0);

    // shifted key, with and without lead
    push_one(7'h0A);
    exp_q.push_back(7'h7F);
    sb_key(1'b0, 7'h0A, 2);
    drain();
    in_valid0 = 1'b1;
    in_code0  = 7'h0A;
    step();
    in_valid0 = 1'b0;
    exp0_q.push_back(7'h7F);
    sb_key(1'b1, 7'h0A, 0);
    drain();
    chk("nolead_busy_end", {7'd0, busy0}, 8'd0);

    // back-pressure with in_valid held
    idx = 0;
    guard = 0;
    in_valid = 1'b1;
    in_code = bp[0];
    while (idx < 6 && guard < 300) begin
      acc = in_ready;
      step();
      guard++;
      if (acc) begin
        if (idx == 0) exp_q.push_back(7'h7F);
        sb_key(1'b0, bp[idx], 2);
        idx++;
        if (idx == 5) begin
          chk("bp_full_ready", {7'd0, in_ready}, 8'd0);
          chk("bp_full_count", {5'd0, fifo_count}, 8'd4);
        end
        if (idx < 6) in_code = bp[idx];
      end
    end
    in_valid = 1'b0;
    chk("bp_accepted", 8'(idx), 8'd6);
    drain();
    chk("bp_busy_end", {7'd0, busy}, 8'd0);

    // flush mid-PRESS with three queued
    in_valid = 1'b1;
    in_code = 7'h4A; step();
    in_code = 7'h15; step();
    in_code = 7'h6C; step();
    in_code = 7'h0A; step();
    chk("fl_pressing", {1'b0, key_code}, 8'h4A);
    chk("fl_queued", {5'd0, fifo_count}, 8'd3);
    in_code = 7'h55;
    flush = 1'b1;
    #1;
    chk("fl_ready", {7'd0, in_ready}, 8'd0);
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_key", {1'b0, key_code}, 8'h7F);
    chk("fl_count", {5'd0, fifo_count}, 8'd0);
    chk("fl_busy", {7'd0, busy}, 8'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("fl_quiet_key", {1'b0, key_code}, 8'h7F);
    end
    push_one(7'h4C);
    exp_q.push_back(7'h7F);
    sb_key(1'b0, 7'h4C, 2);
    drain();

    // reset mid-LEAD with queued codes
    in_valid = 1'b1;
    in_code = 7'h0A; step();
    in_code = 7'h15; step();
    in_code = 7'h6C; step();
    in_valid = 1'b0;
    chk("rl_lead", {1'b0, key_code}, 8'h3F);
    chk("rl_count", {5'd0, fifo_count}, 8'd2);
    reset = 1'b1;
    #1;
    chk("rl_ready_in_reset", {7'd0, in_ready}, 8'd0);
    step();
    chk("rl_key", {1'b0, key_code}, 8'h7F);
    chk("rl_count0", {5'd0, fifo_count}, 8'd0);
    chk("rl_busy", {7'd0, busy}, 8'd0);
    reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("rl_no_stale", {1'b0, key_code}, 8'h7F);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_sequencer.md
Name: key_sequencer

Overview:
- Queued key-injection controller in front of the CoCo key matrix. Drives its 7-bit key_code: bit 6 = shift, active low; bits 5:3 = column; bits 2:0 = row.
- Accepts key codes from an upstream source (PS/2 translator, UART paste/auto-type) through a valid/ready FIFO.
- Presents each key as a timed press/release so 6809 scan software sees every keystroke, including fast bursts.
- Applies shift ahead of shifted keys so the matrix never sees key-before-shift.

Parameters:
- DEPTH, 16, FIFO entries; power of two, at least 2.
- HOLD_CYCLES, 1000000, clocks a key stays asserted; at least 1.
- GAP_CYCLES, 1000000, clocks of all-released between keys; at least 1.
- SHIFT_LEAD, 250000, clocks shift is asserted alone before a shifted key; 0 disables the lead phase.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream has a key code
- in_code  in  7  key code, same format as the key_code output
- in_ready  out  1  FIFO can accept; a transfer occurs on a rising edge with in_valid and in_ready both high
- flush  in  1  discard the queue and the current key
- key_code  out  7  registered drive to the key matrix
- busy  out  1  FIFO non-empty or FSM not IDLE
- fifo_count  out  $clog2(DEPTH)+1  entries queued

Behaviour:
- Idle code 7'h7F: shift released, column 7 / row 7, which is no key. Shift-only code is 7'h3F.
- Reset: FIFO emptied, fifo_count=0, state IDLE, key_code=7'h7F, busy=0. in_ready is 0 while reset is high and 1 in the first cycle after.
- in_ready = !full && !flush. It is combinational from registered count.
- Push and pop in the same cycle: count unchanged. When full, a same-cycle pop does not open in_ready.
- FIFO pointers wrap modulo DEPTH. fifo_count saturates at DEPTH by construction. Data is stored unmodified.
- FSM states: IDLE, LEAD, PRESS, GAP. A down-counter is sized for the largest parameter.
- IDLE:
  - If FIFO is non-empty, pop into cur.
  - If cur[6]==0 and SHIFT_LEAD>0: go to LEAD, key_code<=7'h3F, counter<=SHIFT_LEAD-1.
  - Otherwise: go to PRESS, key_code<=cur, counter<=HOLD_CYCLES-1.
  - If FIFO is empty, stay and hold key_code=7'h7F.
- LEAD: when counter==0, go to PRESS, key_code<=cur, counter<=HOLD_CYCLES-1. Otherwise decrement.
- PRESS: when counter==0, go to GAP, key_code<=7'h7F, counter<=GAP_CYCLES-1.
- GAP: when counter==0, go to IDLE. Otherwise decrement.
- Timing per key:
  - Plain key: exactly HOLD_CYCLES cycles of the code, then GAP_CYCLES cycles of 7'h7F, then 1 IDLE cycle (also 7'h7F) before the next key.
  - Shifted key with lead: SHIFT_LEAD cycles of 7'h3F precede the hold.
- Latency: a code accepted at edge t into an empty, IDLE block appears on key_code after edge t+2.
- Shift-only entry (7'h3F) is legal and is sequenced like any shifted key.
- Entry with row 7 and shift high (e.g. 7'h7F) is legal: it holds for HOLD+GAP as a timed pause.
- flush (synchronous, any state):
  - Next edge: FIFO empty, state IDLE, key_code=7'h7F.
  - in_valid during flush is not accepted.
  - flush beats pop on the same edge.
- reset beats flush.
- busy is registered-equivalent: computed from registered state/count. It is 0 only in IDLE with an empty FIFO.

Test Plan (DEPTH=4, HOLD_CYCLES=4, GAP_CYCLES=3, SHIFT_LEAD=2 unless noted):
- Reset check: hold reset 3 cycles -> key_code=7'h7F, busy=0, fifo_count=0; in_ready=0 during reset and 1 after.
- Plain key: push 7'h4A into idle -> key_code=7'h4A from edge t+2 for 4 cycles, then 7'h7F for 3 cycles; busy drops after IDLE is re-entered with empty FIFO.
- Shifted key: push 7'h0A -> 7'h3F for 2 cycles, 7'h0A for 4 cycles, 7'h7F for 3. Repeat with SHIFT_LEAD=0 -> no 7'h3F phase.
- Full/back-pressure: push 6 codes back-to-back with in_valid held -> one popped immediately, then four accepted and in_ready low until a pop; all 6 codes emerge in order with correct per-key timing; no loss or duplicate.
- Flush mid-PRESS with 3 queued and in_valid high -> next edge key_code=7'h7F, fifo_count=0, the flush-cycle push is not accepted; sequencing resumes cleanly with the next accepted push.
- Reset mid-LEAD with queued codes -> key_code=7'h7F, FIFO empty, and no stale code presented after reset release.
